percept_ctrl: RTL and testbench

Command controller between the `uart` byte interface and the `percept` datapath in the `perceptron` top. Parses received bytes into load / multiply-accumulate / read commands, drives `percept` strobes and `data_in`, and serialises the `percept` result back to the UART transmitter MSB-first. One command executes at a time; bytes arriving while busy are dropped and flagged.

---
 rtl/percept_ctrl_pkg.sv | 9 +
 rtl/percept_ctrl_txser.sv | 47 ++++
 rtl/percept_ctrl.sv | 109 ++++++++++
 tb/tb_percept_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/percept_ctrl_pkg.sv
// percept_ctrl_pkg: opcodes and FSM states shared by the controller and its bench.
package percept_ctrl_pkg;
    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_MAC  = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    typedef enum logic [2:0] {
        IDLE, LOAD_BYTES, LOAD_PUSH, MAC_WAIT, READ_REQ, READ_CAP, TX_SEND, TX_WAIT
    } state_t;
endpackage

// File: rtl/percept_ctrl_txser.sv
// percept_ctrl_txser: MSB-first byte serialiser with busy_tx handshake for the TX_SEND/TX_WAIT states.
module percept_ctrl_txser #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic              sending,
    input  logic              waiting,
    input  logic              busy_tx,
    output logic              fire,
    output logic              fin,
    output logic              done,
    output logic              transmit,
    output logic [7:0]        data_tx
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB + 1);
    logic [DATA_W-1:0] sh;
    logic [LW-1:0]     left;
    logic              ign;
    // the cycle right after a send still shows the previous busy_tx, so it is skipped
    assign fire = sending && !busy_tx;
    assign fin  = waiting && !ign && !busy_tx;
    assign done = fin && left == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            sh       <= '0;
            left     <= '0;
            ign      <= 1'b0;
            transmit <= 1'b0;
            data_tx  <= '0;
        end else begin
            transmit <= fire;
            ign      <= fire;
            if (load) begin
                sh   <= word;
                left <= LW'(NB);
            end else if (fire) begin
                data_tx <= sh[DATA_W-1 -: 8];
                sh      <= sh << 8;
                left    <= left - 1'b1;
            end
        end
    end
endmodule

// File: rtl/percept_ctrl.sv
// percept_ctrl: UART byte command parser driving the percept datapath (LOAD / MAC / READ).
// Optional inter-byte load timeout enabled by defining PCTRL_TIMEOUT_EN.
module percept_ctrl
    import percept_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAC_CYCLES = 4
`ifdef PCTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              recieved,
    input  logic [7:0]        data_rx,
    input  logic              busy_tx,
    output logic              transmit,
    output logic [7:0]        data_tx,
    output logic              shift_in,
    output logic [DATA_W-1:0] data_in,
    output logic              mul_and_acc,
    output logic              shift_out,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              err
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2((MAC_CYCLES > NB ? MAC_CYCLES : NB) + 1);
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] asm_q;
    logic              fire, fin, done;
`ifdef PCTRL_TIMEOUT_EN
    logic [31:0]       to;
`endif
    assign busy = state != IDLE;
    percept_ctrl_txser #(.DATA_W(DATA_W)) u_txser (
        .clk(clk), .rst(nRst), .load(state == READ_CAP), .word(data_out),
        .sending(state == TX_SEND), .waiting(state == TX_WAIT), .busy_tx(busy_tx),
        .fire(fire), .fin(fin), .done(done), .transmit(transmit), .data_tx(data_tx)
    );
    always_ff @(posedge clk) begin
        if (nRst) begin
            state       <= IDLE;
            cnt         <= '0;
            asm_q       <= '0;
            data_in     <= '0;
            shift_in    <= 1'b0;
            mul_and_acc <= 1'b0;
            shift_out   <= 1'b0;
            err         <= 1'b0;
`ifdef PCTRL_TIMEOUT_EN
            to          <= '0;
`endif
        end else begin
            shift_in    <= 1'b0;
            mul_and_acc <= 1'b0;
            shift_out   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
`ifdef PCTRL_TIMEOUT_EN
                    to  <= '0;
`endif
                    if (recieved) begin
                        state       <= data_rx == OP_LOAD ? LOAD_BYTES :
                                       data_rx == OP_MAC  ? MAC_WAIT   :
                                       data_rx == OP_READ ? READ_REQ   : IDLE;
                        mul_and_acc <= data_rx == OP_MAC;
                        shift_out   <= data_rx == OP_READ;
                        err         <= err || !(data_rx inside {OP_LOAD, OP_MAC, OP_READ});
                    end
                end
                LOAD_BYTES: begin
`ifdef PCTRL_TIMEOUT_EN
                    to <= recieved ? '0 : to + 1'b1;
`endif
                    if (recieved) begin
                        asm_q <= DATA_W'({asm_q, data_rx});
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(NB - 1)) begin
                            data_in  <= DATA_W'({asm_q, data_rx});
                            shift_in <= 1'b1;
                            state    <= LOAD_PUSH;
                        end
                    end
`ifdef PCTRL_TIMEOUT_EN
                    else if (to == 32'(TIMEOUT_CYCLES - 1)) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end
`endif
                end
                LOAD_PUSH: state <= IDLE;
                MAC_WAIT: begin
                    cnt   <= cnt + 1'b1;
                    state <= cnt == CW'(MAC_CYCLES - 1) ? IDLE : MAC_WAIT;
                end
                READ_REQ: state <= READ_CAP;
                READ_CAP: state <= TX_SEND;
                TX_SEND:  state <= fire ? TX_WAIT : TX_SEND;
                TX_WAIT:  state <= !fin ? TX_WAIT : done ? IDLE : TX_SEND;
            endcase
            // any byte outside IDLE/LOAD_BYTES is dropped
            if (recieved && state != IDLE && state != LOAD_BYTES)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_percept_ctrl.sv
// tb_percept_ctrl: directed scoreboard bench for percept_ctrl (timeout case built with PCTRL_TIMEOUT_EN).
module tb_percept_ctrl;
    import percept_ctrl_pkg::*;
    typedef struct {int k; logic [15:0] v;} exp_t;
    logic        clk = 1'b0;
    logic        nRst = 1'b1;
    logic        recieved = 1'b0;
    logic [7:0]  data_rx = 8'h00;
    logic        busy_tx;
    logic        transmit, shift_in, mul_and_acc, shift_out, busy, err;
    logic [7:0]  data_tx;
    logic [15:0] data_in;
    logic [15:0] data_out = 16'hDEAD;
    logic [15:0] rd_word = 16'hBEEF;
    int          btcnt = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        q[$];
    always #5 clk = ~clk;
    percept_ctrl #(
        .DATA_W(16), .MAC_CYCLES(4)
`ifdef PCTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .nRst(nRst), .recieved(recieved), .data_rx(data_rx), .busy_tx(busy_tx),
        .transmit(transmit), .data_tx(data_tx), .shift_in(shift_in), .data_in(data_in),
        .mul_and_acc(mul_and_acc), .shift_out(shift_out), .data_out(data_out),
        .busy(busy), .err(err)
    );
    // percept result valid only the cycle after shift_out; UART busy 10 cycles per byte
    always @(posedge clk) begin
        data_out <= shift_out ? rd_word : 16'hDEAD;
        btcnt    <= transmit ? 10 : btcnt != 0 ? btcnt - 1 : 0;
    end
    assign busy_tx = btcnt != 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        int   n;
        exp_t e;
        n = int'(shift_in === 1'b1) + int'(mul_and_acc === 1'b1) + int'(shift_out === 1'b1) + int'(transmit === 1'b1);
        if (n > 1) chk("one_strobe", n, 1);
        if (transmit === 1'b1) chk("tx_busy_low", busy_tx, 0);
        if (n != 0) begin
            if (q.size() == 0) chk("unexpected_strobe", n, 0);
            else begin
                e = q.pop_front();
                chk("sb_kind", transmit ? 3 : shift_out ? 2 : mul_and_acc ? 1 : 0, e.k);
                chk("sb_val", shift_in ? 32'(data_in) : transmit ? 32'(data_tx) : 0, 32'(e.v));
            end
        end
    end
    task automatic send(input logic [7:0] b);
        recieved = 1'b1;
        data_rx  = b;
        @(negedge clk);
        recieved = 1'b0;
    endtask
    task automatic do_reset();
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        nRst = 1'b0;
    endtask
    task automatic wait_idle(input int n);
        for (int i = 0; i < n && busy; i++) @(negedge clk);
        chk("idle_bound", busy, 0);
    endtask
    task automatic load(input logic [15:0] w);
        send(OP_LOAD);
        send(w[15:8]);
        q.push_back('{0, w});
        send(w[7:0]);
        chk("load_shift_in", shift_in, 1);
        chk("load_data_in", data_in, w);
        @(negedge clk);
        chk("load_done", busy, 0);
    endtask
    initial begin
        int b;
        @(negedge clk);
        do_reset();
        chk("rst_outs", {transmit, shift_in, mul_and_acc, shift_out, busy, err}, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_data_tx", data_tx, 0);
        load(16'h1234);
        chk("load_err", err, 0);
        send(8'h7F);
        chk("bad_op_err", err, 1);
        chk("bad_op_state", dut.state, IDLE);
        q.push_back('{1, 16'h0});
        send(OP_MAC);
        chk("mac_after_bad", mul_and_acc, 1);
        wait_idle(20);
        do_reset();
        q.push_back('{1, 16'h0});
        send(OP_MAC);
        chk("mac_pulse", mul_and_acc, 1);
        b = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) b++;
            recieved = i == 1;
            data_rx  = OP_READ;
            @(negedge clk);
        end
        recieved = 1'b0;
        chk("mac_busy_cycles", b, 4);
        chk("mac_drop_err", err, 1);
        q.push_back('{1, 16'h0});
        send(OP_MAC);
        for (int i = 0; i < 6; i++) begin
            recieved = i == 3;
            data_rx  = OP_READ;
            @(negedge clk);
        end
        recieved = 1'b0;
        chk("mac_last_drop", busy, 0);
        q.push_back('{2, 16'h0});
        q.push_back('{3, 16'h00BE});
        q.push_back('{3, 16'h00EF});
        send(OP_READ);
        chk("read_shift_out", shift_out, 1);
        wait_idle(200);
        chk("read_sb_empty", q.size(), 0);
        chk("read_last_byte", data_tx, 8'hEF);
        load(16'hABCD);
        send(OP_LOAD);
        send(8'hAA);
        nRst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {transmit, shift_in, mul_and_acc, shift_out, busy, err}, 0);
        chk("midrst_data_in", data_in, 0);
        chk("midrst_data_tx", data_tx, 0);
        nRst = 1'b0;
        load(16'h0001);
`ifdef PCTRL_TIMEOUT_EN
        do_reset();
        send(OP_LOAD);
        send(8'hAA);
        repeat (105) @(negedge clk);
        chk("to_idle", busy, 0);
        chk("to_err", err, 1);
        chk("to_data_in", data_in, 0);
        load(16'h5566);
`endif
        repeat (5) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
